// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide controller.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 32;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV,
    ST_DIV_FIX,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_e;

  // Radix-2 Booth recoding of the {Q[0], q-1} pair.
  function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/multdiv_ctrl_addsub32.sv
// Shared add/subtract path: b is conditionally inverted and sub is the carry-in.
module addsub32
  import multdiv_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_x;

  assign b_x         = b ^ {WIDTH{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/multdiv_ctrl.sv
// Multicycle signed multiply (radix-2 Booth) / divide (non-restoring) controller.
// Divide support is built only when MULTDIV_DIV_EN is defined.
module multdiv_ctrl
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [5:0] CNT_LAST = 6'(STEPS - 1);
  localparam logic [5:0] CNT_FIN  = 6'(STEPS);

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
`ifdef MULTDIV_DIV_EN
  logic             neg_q, neg_d;
`endif

  logic [WIDTH-1:0] as_a, as_b, as_sum;
  logic             as_sub, as_cout;
  booth_op_e        bop;
  logic             mul_sign;
  logic [WIDTH-1:0] mul_val;
  logic [WIDTH:0]   prod_hi;
  logic             mul_ovf;

  addsub32 u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  // Operand steering for the single shared adder.
  always_comb begin
    as_a   = acc_q;
    as_b   = m_q;
    as_sub = 1'b0;
    bop    = booth_decode(q_q[0], qm1_q);
    case (state_q)
      ST_MUL: as_sub = (bop == BOOTH_SUB);
`ifdef MULTDIV_DIV_EN
      ST_DIV_PREP: begin
        as_a   = '0;
        as_b   = (cnt_q == 6'd0) ? q_q : m_q;
        as_sub = 1'b1;
      end
      ST_DIV: begin
        as_a   = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
        as_sub = ~acc_q[WIDTH-1];
      end
      ST_DIV_FIX: begin
        as_a   = '0;
        as_b   = q_q;
        as_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // The 32-bit sum can wrap (e.g. subtracting INT_MIN); the true 33-bit sign
  // is recovered from the operand signs and carry-out before the shift.
  always_comb begin
    mul_val  = (bop == BOOTH_NOP) ? acc_q : as_sum;
    mul_sign = (bop == BOOTH_NOP) ? acc_q[WIDTH-1]
                                  : (acc_q[WIDTH-1] ^ m_q[WIDTH-1] ^ as_sub ^ as_cout);
    prod_hi  = {acc_q, q_q[WIDTH-1]};
    mul_ovf  = ~((&prod_hi) | ~(|prod_hi));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    err_d   = err_q;
    res_d   = res_q;
    exc_d   = exc_q;
`ifdef MULTDIV_DIV_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          state_d = ST_MUL;
          cnt_d   = '0;
          acc_d   = '0;
          q_d     = data_operandA;
          qm1_d   = 1'b0;
          m_d     = data_operandB;
          err_d   = 1'b0;
        end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
          state_d = ST_DIV_PREP;
          cnt_d   = '0;
          acc_d   = '0;
          q_d     = data_operandA;
          qm1_d   = 1'b0;
          m_d     = data_operandB;
          err_d   = (data_operandA == INT_MIN) && (data_operandB == '1);
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`else
          // Unsupported divide: reuse the multiply finish cycle to flag it.
          state_d = ST_MUL;
          cnt_d   = CNT_FIN;
          acc_d   = '0;
          q_d     = '0;
          qm1_d   = 1'b0;
          m_d     = '0;
          err_d   = 1'b1;
`endif
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_FIN) begin
          state_d = ST_DONE;
          res_d   = err_q ? '0 : q_q;
          exc_d   = err_q | mul_ovf;
        end else begin
          acc_d = {mul_sign, mul_val[WIDTH-1:1]};
          q_d   = {mul_val[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q + 6'd1;
        end
      end
`ifdef MULTDIV_DIV_EN
      ST_DIV_PREP: begin
        if (cnt_q == 6'd0) begin
          if (m_q == '0) begin
            state_d = ST_DONE;
            res_d   = '0;
            exc_d   = 1'b1;
          end else begin
            q_d   = q_q[WIDTH-1] ? as_sum : q_q;
            cnt_d = 6'd1;
          end
        end else begin
          m_d     = m_q[WIDTH-1] ? as_sum : m_q;
          cnt_d   = '0;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        acc_d = as_sum;
        q_d   = {q_q[WIDTH-2:0], ~as_sum[WIDTH-1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DIV_FIX;
          cnt_d   = '0;
        end
      end
      ST_DIV_FIX: begin
        if (cnt_q == 6'd0) begin
          if (neg_q) q_d = as_sum;
          cnt_d = 6'd1;
        end else begin
          state_d = ST_DONE;
          res_d   = q_q;
          exc_d   = err_q;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      err_q   <= err_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

`ifdef MULTDIV_DIV_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) neg_q <= 1'b0;
    else          neg_q <= neg_d;
  end
`endif

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Multicycle signed multiply/divide unit. It sits beside the ALU and reuses one shared 32-bit add/subtract path, a conditional inverter plus carry-in adder, for every partial-product and partial-remainder step. The controller sequences that path through radix-2 Booth multiplication (32 steps) and non-restoring division (32 steps plus sign fix-up). It reports the result, an exception flag and a one-cycle ready strobe to the pipeline's multdiv stall logic.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  one-cycle start pulse for multiply
- ctrl_DIV  in  1  one-cycle start pulse for divide
- data_operandA  in  32  multiplicand / dividend, sampled with the start pulse
- data_operandB  in  32  multiplier / divisor, sampled with the start pulse
- data_result  out  32  low 32 bits of the product, or the quotient
- data_exception  out  1  overflow or divide-by-zero
- data_resultRDY  out  1  high for exactly one cycle when the result is valid
- busy  out  1  high from the accepted start until the RDY cycle, inclusive

## Operation
- Reset (async assert, sync release): state IDLE. data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, all internal registers cleared.
- Start pulses are accepted only in IDLE. Pulses while busy are ignored and have no side effects.
- If ctrl_MULT and ctrl_DIV arrive in the same cycle, MULT wins.
- Operands are latched internally on the accepted edge. Later operand changes are ignored.
- States: IDLE → MUL → DONE; IDLE → DIV_PREP → DIV → DIV_FIX → DONE; DONE → IDLE.
- MUL: 65-bit {acc, Q, q-1} register. Each step inspects {Q[0], q-1}:
  - 01: add B
  - 10: subtract B (invert + carry-in 1)
  - 00/11: no add
  - then arithmetic right shift
  - Step counter runs 0..31.
- Multiply overflow: exception = 1 when product bits [63:31] are not all equal. The result is still the low 32 bits.
- DIV_PREP: two cycles. Cycle 1 computes |A|, cycle 2 computes |B|, each as 0 − x through the shared path. The sign XOR is latched.
- DIV: 32 non-restoring steps. Shift {R, Q} left. Subtract |B| if R ≥ 0, else add. Q[0] = ~R_new[31].
- DIV_FIX: negate the quotient if the sign XOR = 1. The remainder is discarded. Truncation is toward zero.
- Divide by zero (B = 0): skips the sequence. Go to DONE on the next edge with result 0, exception 1.
- 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
- data_result and data_exception update only on entry to DONE. They hold their value until the next DONE.
- Reset mid-operation: abort immediately. No RDY is produced and outputs return to reset values.

## Timing
- t0 = the edge that samples the start pulse.
- Multiply: steps on t1..t32. data_resultRDY is high in the cycle after t33.
- Divide: DIV_PREP on t1..t2, steps on t3..t34, DIV_FIX on t35. RDY is high in the cycle after t36.
- Divide by zero: RDY is high in the cycle after t1.
- busy rises after t0 and falls together with RDY.
- A new start is accepted on the edge ending the RDY cycle at the earliest.
- Exactly one add/subtract pass per cycle; no combinational path from inputs to outputs.

## Configuration
- MULTDIV_DIV_EN defined: full divide support as above.
- MULTDIV_DIV_EN undefined:
  - divide datapath and DIV_* states are not built
  - an accepted ctrl_DIV goes straight to DONE (RDY in the cycle after t1), with result 0 and exception 1
  - multiply is unchanged

## Structure
- Package multdiv_pkg:
  - state encoding (IDLE, MUL, DIV_PREP, DIV, DIV_FIX, DONE)
  - WIDTH = 32, STEPS = 32
  - Booth op codes (NOP, ADD, SUB)
  - INT_MIN constant
- Sub-module addsub32: bitwise conditional invert of the B input by a sub control, feeding the 32-bit adder with carry-in = sub. Outputs sum and carry-out.
- Exactly one addsub32 instance, muxed between the MUL, DIV_PREP, DIV and DIV_FIX operands.

## Test plan
- 7 × −3 (0x00000007, 0xFFFFFFFD) → result 0xFFFFFFEB, exception 0, RDY in the cycle after t33, busy low afterward.
- 0x00010000 × 0x00010000 → result 0x00000000, exception 1. 0x7FFFFFFF × 1 → 0x7FFFFFFF, exception 0.
- −100 / 7 → 0xFFFFFFF2, exception 0, RDY in the cycle after t36. 100 / −7 → 0xFFFFFFF2.
- 5 / 0 → result 0, exception 1, RDY in the cycle after t1.
- 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1.
- Busy/reset interaction:
  - ctrl_DIV pulse at t5 of a multiply → ignored, multiply result correct.
  - reset_n low at t10 → all outputs 0 immediately, no RDY.
  - a new multiply after release completes normally.
